decode_sequencer: RTL and testbench
===================================

// Module: decode_sequencer
// PURPOSE
// - Registered decode + instruction sequencer stage for the E0C6S46 CPU core; sits between fetch and microcode ROM.
// - Accepts a fetched opcode via valid/ready, decodes it to a microcode start address and instruction cycle length.
// - Counts out the instruction's clock cycles and issues per-step microcode addresses, last-step and done strobes.
// - Successor to the combinational decoder: parametrised widths, clock-enable stall, back-to-back issue, undefined-opcode handling.
// PARAMETERS
// - OPCODE_W   12     opcode width; decode keys on opcode[OPCODE_W-1 -: 4]
// - UADDR_W    7      microcode address width
// - STEP_W     4      step counter width; must hold 12 (longest instruction)
// - NOP_ADDR   7'h7F  microcode start address issued for undefined opcodes
// PORTS
// - clk             in   1         core clock
// - reset           in   1         asynchronous, active-high reset
// - cpu_en          in   1         CPU clock enable; all state advances only when high
// - opcode          in   OPCODE_W  fetched instruction word
// - opcode_valid    in   1         opcode is valid this cycle
// - opcode_ready    out  1         sequencer will accept opcode when cpu_en && opcode_valid
// - uaddr           out  UADDR_W   current microcode address (start + step)
// - step            out  STEP_W    step index within current instruction, 0-based
// - last_step       out  1         current step is final step of instruction
// - busy            out  1         instruction executing
// - done            out  1         one-cycle pulse after final step retires
// - skip_pc_increment out 1        held for whole instruction (RETD, CALL, CALZ)
// - immed           out  8         registered opcode[7:0] of current instruction
// - illegal         out  1         see CONFIGURATION
// BEHAVIOUR
// - Reset: state IDLE; all outputs 0 except opcode_ready=1. Async reset mid-instruction aborts it, no done pulse.
// - Decode table (top nibble -> start addr, length): 0 JP s ->0,5; 1 RETD e ->1,12,skip; 2 JP C ->2,5; 3 JP NC ->3,5;
//   4 CALL ->4,7,skip; 5 CALZ ->5,7,skip; 6 JP Z ->6,5; 7 JP NZ ->7,5; 8 LD Y,e ->8,5; 9 LBPX MX,e ->9,5;
//   A-F undefined -> NOP_ADDR,5, no skip.
// - FSM IDLE: opcode_ready=1. Accept on cpu_en&&opcode_valid: latch start addr, length, skip, immed; step=0; go EXEC.
// - FSM EXEC: busy=1. Each cpu_en cycle step increments; uaddr = start + step, UADDR_W-bit wrap-around (no saturation).
//   last_step = (step == length-1). On cpu_en at last_step: done pulses next cycle.
// - Back-to-back: opcode_ready=1 also during EXEC when last_step; accepting then reloads with step=0, stays EXEC, still pulses done.
// - No accept at last_step -> return IDLE; skip_pc_increment, busy clear.
// - cpu_en low: every register holds, including step and outputs; done is a single clk pulse, not stretched by cpu_en.
// - opcode_valid while busy and not last_step: ignored; opcode_ready=0.
// - Latency: accept edge -> step 0 visible next clk; instruction of length N occupies exactly N cpu_en cycles.
// CONFIGURATION
// - Macro DECODE_ILLEGAL_TRAP_EN.
// - Defined: opcodes A-F set illegal=1 for the whole instruction, decoded to NOP_ADDR, length 5 as usual;
//   illegal clears on next accept of a defined opcode or reset.
// - Undefined: illegal tied 0; A-F silently run as NOP_ADDR,5.
// TESTING
// - Reset mid-RETD (step 6) -> next clk busy=0, step=0, opcode_ready=1, no done.
// - cpu_en=1, opcode 12'h123 -> uaddr 1..12, immed=8'h23, skip=1 for 12 cycles, done pulse after step 11.
// - cpu_en toggling 1/0, opcode 12'h4AB -> 7 enabled steps over 14 clks, uaddr 4..10, skip=1, done once.
// - Back-to-back 12'h055 then 12'h877 at last_step -> uaddr 0..4 then 8..12, no IDLE gap, two done pulses.
// - opcode 12'hF00 -> uaddr 7F,00,01,02,03 (wrap); illegal=1 with trap macro, 0 without.
// - opcode_valid held high while busy with different opcode -> ignored until last_step; accepted opcode = one sampled then.

Source files
------------

// File: rtl/decode_sequencer.sv
// Registered decode + instruction sequencer: accepts an opcode, issues per-step microcode addresses.
// Optional undefined-opcode trap flag enabled by defining DECODE_ILLEGAL_TRAP_EN.
module decode_sequencer #(
    parameter int                 OPCODE_W = 12,
    parameter int                 UADDR_W  = 7,
    parameter int                 STEP_W   = 4,
    parameter logic [UADDR_W-1:0] NOP_ADDR = 7'h7F
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cpu_en,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                opcode_valid,
    output logic                opcode_ready,
    output logic [UADDR_W-1:0]  uaddr,
    output logic [STEP_W-1:0]   step,
    output logic                last_step,
    output logic                busy,
    output logic                done,
    output logic                skip_pc_increment,
    output logic [7:0]          immed,
    output logic                illegal
);

    typedef enum logic {IDLE, EXEC} state_t;

    state_t             state, state_next;
    logic [UADDR_W-1:0] start_addr;
    logic [STEP_W-1:0]  step_cnt;
    logic [STEP_W-1:0]  last_idx;
    logic               skip_reg;
    logic [7:0]         immed_reg;
    logic               done_reg;

    logic [3:0]         nibble;
    logic [UADDR_W-1:0] dec_addr;
    logic [STEP_W-1:0]  dec_last;
    logic               dec_skip;
    logic               in_last;
    logic               accept;

    assign nibble = opcode[OPCODE_W-1 -: 4];

    // Decode table: start address and index of the final step (length - 1).
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        dec_addr = NOP_ADDR;
        dec_last = STEP_W'(4);
        dec_skip = 1'b0;
        if (nibble <= 4'h9) dec_addr = UADDR_W'(nibble);
        case (nibble)
            4'h1:       begin dec_last = STEP_W'(11); dec_skip = 1'b1; end
            4'h4, 4'h5: begin dec_last = STEP_W'(6);  dec_skip = 1'b1; end
            default:    ;
        endcase
    end

    assign busy         = (state == EXEC);
    assign in_last      = busy && (step_cnt == last_idx);
    assign opcode_ready = (state == IDLE) || in_last;
    assign accept       = cpu_en && opcode_valid && opcode_ready;

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (cpu_en) begin
            case (state)
                IDLE:    if (accept) state_next = EXEC;
                EXEC:    if (in_last && !accept) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_addr <= '0;
            step_cnt   <= '0;
            last_idx   <= '0;
            skip_reg   <= 1'b0;
            immed_reg  <= 8'h00;
            done_reg   <= 1'b0;
        end else begin
            // done retires every clk so it never stretches while cpu_en is low.
            done_reg <= cpu_en && in_last;
            if (cpu_en) begin
                if (accept) begin
                    start_addr <= dec_addr;
                    last_idx   <= dec_last;
                    skip_reg   <= dec_skip;
                    immed_reg  <= opcode[7:0];
                    step_cnt   <= '0;
                end else if (in_last) begin
                    step_cnt <= '0;
                    skip_reg <= 1'b0;
                end else if (busy) begin
                    step_cnt <= step_cnt + 1'b1;
                end
            end
        end
    end

`ifdef DECODE_ILLEGAL_TRAP_EN
    logic illegal_reg;

    // Sticky until the next accepted opcode, so it survives the return to IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)       illegal_reg <= 1'b0;
        else if (accept) illegal_reg <= (nibble > 4'h9);
    end

    assign illegal = illegal_reg;
`else
    assign illegal = 1'b0;
`endif

    assign uaddr             = busy ? start_addr + UADDR_W'(step_cnt) : '0;
    assign step              = step_cnt;
    assign last_step         = in_last;
    assign done              = done_reg;
    assign skip_pc_increment = skip_reg;
    assign immed             = immed_reg;

endmodule

// File: tb/tb_decode_sequencer.sv
// Scoreboard bench for decode_sequencer: each accepted opcode pushes its expected step records,
// which are popped and compared as the DUT retires steps.
module tb_decode_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_en;
    logic [11:0] opcode;
    logic        opcode_valid;
    logic        opcode_ready;
    logic [6:0]  uaddr;
    logic [3:0]  step;
    logic        last_step;
    logic        busy;
    logic        done;
    logic        skip_pc_increment;
    logic [7:0]  immed;
    logic        illegal;

`ifdef DECODE_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    decode_sequencer dut (
        .clk               (clk),
        .reset             (reset),
        .cpu_en            (cpu_en),
        .opcode            (opcode),
        .opcode_valid      (opcode_valid),
        .opcode_ready      (opcode_ready),
        .uaddr             (uaddr),
        .step              (step),
        .last_step         (last_step),
        .busy              (busy),
        .done              (done),
        .skip_pc_increment (skip_pc_increment),
        .immed             (immed),
        .illegal           (illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] uaddr;
        logic [3:0] step;
        logic       last;
        logic       skip;
        logic [7:0] immed;
    } rec_t;

    rec_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   acc_cnt = 0;
    int   cyc = 0;
    int   prev_acc = 0;
    int   last_acc = 0;
    logic exp_done_q = 1'b0;
    logic exp_ill = 1'b0;
    bit   toggle_mode = 1'b0;
    bit   busy_e, ready_e, nxt_done;
    rec_t front;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Expected step sequence straight from the decode table.
    task automatic push_instr(input logic [11:0] op);
        logic [3:0] nib;
        logic [6:0] start;
        int         len;
        rec_t       r;
        nib   = op[11:8];
        start = (nib <= 4'h9) ? {3'b000, nib} : 7'h7F;
        len   = (nib == 4'h1) ? 12 : ((nib == 4'h4 || nib == 4'h5) ? 7 : 5);
        for (int i = 0; i < len; i++) begin
            r.uaddr = start + 7'(i);
            r.step  = 4'(i);
            r.last  = (i == len - 1);
            r.skip  = (nib == 4'h1 || nib == 4'h4 || nib == 4'h5);
            r.immed = op[7:0];
            q.push_back(r);
        end
        exp_ill = TRAP && (nib > 4'h9);
    endtask

    // Monitor: compare at negedge, then advance the model for the coming posedge.
    always @(negedge clk) begin
        if (reset) begin
            q.delete();
            exp_done_q = 1'b0;
            exp_ill    = 1'b0;
        end else begin
            busy_e  = (q.size() != 0);
            ready_e = 1'b1;
            if (busy_e) begin
                front   = q[0];
                ready_e = front.last;
            end
            check("done", 32'(done), 32'(exp_done_q));
            check("busy", 32'(busy), 32'(busy_e));
            check("ready", 32'(opcode_ready), 32'(ready_e));
            check("illegal", 32'(illegal), 32'(exp_ill));
            if (busy_e) begin
                check("uaddr", 32'(uaddr), 32'(front.uaddr));
                check("step", 32'(step), 32'(front.step));
                check("last_step", 32'(last_step), 32'(front.last));
                check("skip", 32'(skip_pc_increment), 32'(front.skip));
                check("immed", 32'(immed), 32'(front.immed));
            end else begin
                check("idle_uaddr", 32'(uaddr), 32'h0);
                check("idle_step", 32'(step), 32'h0);
                check("idle_last", 32'(last_step), 32'h0);
                check("idle_skip", 32'(skip_pc_increment), 32'h0);
            end
            nxt_done = cpu_en && busy_e && front.last;
            if (cpu_en && busy_e) void'(q.pop_front());
            if (cpu_en && opcode_valid && ready_e) begin
                push_instr(opcode);
                prev_acc = last_acc;
                last_acc = cyc;
                acc_cnt++;
            end
            exp_done_q = nxt_done;
        end
        cyc++;
    end

    initial begin
        cpu_en = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cpu_en = toggle_mode ? ~cpu_en : 1'b1;
        end
    end

    task automatic send(input logic [11:0] op);
        int  n0;
        bit  ok;
        n0           = acc_cnt;
        ok           = 1'b0;
        opcode       = op;
        opcode_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (acc_cnt != n0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("accept_timeout", 32'h0, 32'h1);
        opcode_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #2;
            if (q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("idle_timeout", 32'h0, 32'h1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        bit found;
        logic [3:0] nibs [8];
        nibs = '{4'h2, 4'h3, 4'h5, 4'h6, 4'h7, 4'h8, 4'hA, 4'hE};
        reset        = 1'b1;
        opcode       = 12'h000;
        opcode_valid = 1'b0;
        #12;
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_ready", 32'(opcode_ready), 32'h1);
        check("rst_uaddr", 32'(uaddr), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_immed", 32'(immed), 32'h0);
        check("rst_illegal", 32'(illegal), 32'h0);
        @(posedge clk);
        #1 reset = 1'b0;

        send(12'h123);
        wait_idle();

        toggle_mode = 1'b1;
        send(12'h4AB);
        wait_idle();
        toggle_mode = 1'b0;
        @(posedge clk);
        #1;

        // Second opcode is held valid while the first runs; it must be taken exactly at last_step.
        send(12'h055);
        send(12'h877);
        check("b2b_gap", 32'(last_acc - prev_acc), 32'd5);
        wait_idle();

        send(12'hF00);
        wait_idle();
        send(12'h9AA);
        wait_idle();

        foreach (nibs[i]) begin
            send({nibs[i], 8'($urandom_range(0, 255))});
        end
        wait_idle();

        send(12'h1C3);
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #2;
            if (q.size() != 0 && q[0].step == 4'd6) begin
                found = 1'b1;
                break;
            end
        end
        check("reach_step6", 32'(found), 32'h1);
        reset = 1'b1;
        #1;
        check("mid_rst_busy", 32'(busy), 32'h0);
        check("mid_rst_step", 32'(step), 32'h0);
        check("mid_rst_ready", 32'(opcode_ready), 32'h1);
        check("mid_rst_done", 32'(done), 32'h0);
        check("mid_rst_skip", 32'(skip_pc_increment), 32'h0);
        @(posedge clk);
        #1;
        check("post_rst_done", 32'(done), 32'h0);
        check("post_rst_busy", 32'(busy), 32'h0);
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        check("queue_empty", 32'(q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

endmodule
